// File: rtl/execute_stage_p.sv
// Execute stage: registered ALU with valid/ready handshake, flag register, branch
// resolution and an iterative shift-add multiplier.
module execute_stage_p #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 7,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       control_in,
    input  logic [WIDTH-1:0] reg1_data,
    input  logic [WIDTH-1:0] reg2_data,
    input  logic [WIDTH-1:0] npc,
    input  logic [IDX_W-1:0] dest_index_in,
    input  logic [IMM_W-1:0] immediate,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       control_out,
    output logic [IDX_W-1:0] dest_index_out,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic             reg_write_en,
    output logic             branch_taken,
    output logic [WIDTH-1:0] target,
    output logic             zf,
    output logic             gf,
    output logic             lf,
    output logic             busy
);
    // state  | meaning
    // S_IDLE | single-cycle ops accepted directly into the output register
    // S_MUL  | shift-add multiply iterating, input blocked
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [4:0] OP_SUB = 5'd1,  OP_ADD = 5'd2,  OP_ADDI = 5'd3,  OP_SHLLI = 5'd4;
    localparam logic [4:0] OP_SHRLI = 5'd5, OP_JUMP = 5'd6, OP_JUMPL = 5'd7, OP_JUMPG = 5'd8;
    localparam logic [4:0] OP_JUMPE = 5'd9, OP_JUMPNE = 5'd10, OP_CMP = 5'd11, OP_LOAD = 5'd12;
    localparam logic [4:0] OP_LOADI = 5'd13, OP_STORE = 5'd14, OP_MOV = 5'd15, OP_MUL = 5'd16;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic [0:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       control_q, control_d;
    logic [IDX_W-1:0] dest_q, dest_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] store_q, store_d;
    logic             reg_we_q, reg_we_d;
    logic             branch_q, branch_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             zf_q, zf_d, gf_q, gf_d, lf_q, lf_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] mul_dest_q, mul_dest_d;
    logic [WIDTH-1:0] mul_store_q, mul_store_d;

    logic             busy_w, accept, shift_oob;
    logic [WIDTH-1:0] imm_zext, imm_sext, cond_target, acc_step;
    logic [WIDTH-1:0] alu_res, br_target;
    logic             alu_we, alu_arith, alu_cmp, br_taken;

    assign busy_w      = (state_q == S_MUL);
    assign in_ready    = !busy_w && (!out_valid_q || out_ready) && !flush && !reset;
    assign accept      = in_valid && in_ready;
    assign imm_zext    = {{(WIDTH-IMM_W){1'b0}}, immediate};
    assign imm_sext    = {{(WIDTH-IMM_W){immediate[IMM_W-1]}}, immediate};
    assign cond_target = npc + ONE_W + imm_sext;
    assign shift_oob   = (int'(immediate) >= WIDTH);
    assign acc_step    = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        alu_res   = '0;
        alu_we    = 1'b0;
        alu_arith = 1'b0;
        alu_cmp   = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        case (control_in)
            OP_SUB:    begin alu_res = reg1_data - reg2_data; alu_we = 1'b1; alu_arith = 1'b1; end
            OP_ADD:    begin alu_res = reg1_data + reg2_data; alu_we = 1'b1; alu_arith = 1'b1; end
            OP_ADDI:   begin alu_res = reg1_data + imm_zext;  alu_we = 1'b1; alu_arith = 1'b1; end
            OP_SHLLI:  begin
                alu_res = shift_oob ? '0 : reg1_data << immediate;
                alu_we = 1'b1; alu_arith = 1'b1;
            end
            OP_SHRLI:  begin
                alu_res = shift_oob ? '0 : reg1_data >> immediate;
                alu_we = 1'b1; alu_arith = 1'b1;
            end
            OP_JUMP:   begin br_taken = 1'b1; br_target = npc + reg2_data; end
            OP_JUMPL:  begin br_taken = lf_q;  br_target = lf_q  ? cond_target : '0; end
            OP_JUMPG:  begin br_taken = gf_q;  br_target = gf_q  ? cond_target : '0; end
            OP_JUMPE:  begin br_taken = zf_q;  br_target = zf_q  ? cond_target : '0; end
            OP_JUMPNE: begin br_taken = !zf_q; br_target = !zf_q ? cond_target : '0; end
            OP_CMP:    alu_cmp = 1'b1;
            OP_LOAD:   begin alu_res = reg1_data; alu_we = 1'b1; end
            OP_LOADI:  begin alu_res = imm_zext;  alu_we = 1'b1; end
            OP_STORE:  alu_res = reg1_data;
            OP_MOV:    begin alu_res = reg2_data; alu_we = 1'b1; end
            default:   ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        control_d   = control_q;
        dest_d      = dest_q;
        result_d    = result_q;
        store_d     = store_q;
        reg_we_d    = reg_we_q;
        branch_d    = branch_q;
        target_d    = target_q;
        zf_d        = zf_q;
        gf_d        = gf_q;
        lf_d        = lf_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mul_dest_d  = mul_dest_q;
        mul_store_d = mul_store_q;
        if (flush) begin
            out_valid_d = 1'b0;
            branch_d    = 1'b0;
            reg_we_d    = 1'b0;
            state_d     = S_IDLE;
        end else if (busy_w) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (out_ready) out_valid_d = 1'b0;
            if (cnt_q == CNT_LAST) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
                control_d   = OP_MUL;
                dest_d      = mul_dest_q;
                result_d    = acc_step;
                store_d     = mul_store_q;
                reg_we_d    = 1'b1;
                branch_d    = 1'b0;
                target_d    = '0;
                zf_d        = (acc_step == '0);
                gf_d        = 1'b0;
                lf_d        = 1'b0;
            end
        end else if (accept) begin
            if (control_in == OP_MUL) begin
                // Output register is free by construction; the result lands at completion.
                state_d     = S_MUL;
                mcand_d     = reg1_data;
                mplier_d    = reg2_data;
                acc_d       = '0;
                cnt_d       = '0;
                mul_dest_d  = dest_index_in;
                mul_store_d = reg2_data;
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
                control_d   = control_in;
                dest_d      = dest_index_in;
                result_d    = alu_res;
                store_d     = reg2_data;
                reg_we_d    = alu_we;
                branch_d    = br_taken;
                target_d    = br_target;
                if (alu_arith) begin
                    zf_d = (alu_res == '0);
                    gf_d = 1'b0;
                    lf_d = 1'b0;
                end else if (alu_cmp) begin
                    zf_d = (reg1_data == reg2_data);
                    gf_d = ($signed(reg1_data) > $signed(reg2_data));
                    lf_d = ($signed(reg1_data) < $signed(reg2_data));
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            control_q   <= '0;
            dest_q      <= '0;
            result_q    <= '0;
            store_q     <= '0;
            reg_we_q    <= 1'b0;
            branch_q    <= 1'b0;
            target_q    <= '0;
            zf_q        <= 1'b0;
            gf_q        <= 1'b0;
            lf_q        <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_dest_q  <= '0;
            mul_store_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            control_q   <= control_d;
            dest_q      <= dest_d;
            result_q    <= result_d;
            store_q     <= store_d;
            reg_we_q    <= reg_we_d;
            branch_q    <= branch_d;
            target_q    <= target_d;
            zf_q        <= zf_d;
            gf_q        <= gf_d;
            lf_q        <= lf_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mul_dest_q  <= mul_dest_d;
            mul_store_q <= mul_store_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign control_out    = control_q;
    assign dest_index_out = dest_q;
    assign result_out     = result_q;
    assign store_data_out = store_q;
    assign reg_write_en   = reg_we_q;
    assign branch_taken   = branch_q;
    assign target         = target_q;
    assign zf             = zf_q;
    assign gf             = gf_q;
    assign lf             = lf_q;
    assign busy           = busy_w;
endmodule

// File: doc/execute_stage_p.md
# execute_stage_p

Parametrised execute stage for the pipelined core, sitting between decode and memory. It evaluates one decoded instruction per cycle through a registered ALU with a valid/ready handshake. Status flags are registered and held between flag-setting instructions, and branch decisions are resolved in this stage. It adds an iterative multi-cycle MUL, a pipeline flush, and downstream back-pressure.

## Interface
Parameters:
- WIDTH, 16, datapath width (≥8, power of two)
- IMM_W, 7, immediate width (< WIDTH)
- IDX_W, 5, register-index width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- control_in  in  5  opcode
- reg1_data  in  WIDTH  source operand A
- reg2_data  in  WIDTH  source operand B
- npc  in  WIDTH  next-PC of the instruction
- dest_index_in  in  IDX_W  destination register
- immediate  in  IMM_W  immediate field
- flush  in  1  kill in-flight and output-register contents
- out_valid  out  1  output register holds a result
- out_ready  in  1  memory stage consumes the output
- control_out  out  5  registered opcode
- dest_index_out  out  IDX_W  registered destination
- result_out  out  WIDTH  ALU result or address
- store_data_out  out  WIDTH  registered reg2_data
- reg_write_en  out  1  writeback required
- branch_taken  out  1  redirect fetch to target
- target  out  WIDTH  branch target
- zf, gf, lf  out  1 each  flag register
- busy  out  1  MUL iterating

## Operation
- Opcodes: 0 NOP, 1 SUB, 2 ADD, 3 ADDI, 4 SHLLI, 5 SHRLI, 6 JUMP, 7 JUMPL, 8 JUMPG, 9 JUMPE, 10 JUMPNE, 11 CMP, 12 LOAD, 13 LOADI, 14 STORE, 15 MOV, 16 MUL. Opcodes 17–31 behave as NOP.
- Accept on in_valid && in_ready. in_ready = !busy && (!out_valid || out_ready) && !flush.
- Results, all modulo 2^WIDTH:
  - SUB: A−B. ADD: A+B.
  - ADDI: A+zext(imm).
  - SHLLI/SHRLI: logical shift of A by the unsigned imm value; shift ≥ WIDTH gives 0.
  - LOADI: zext(imm). MOV: B.
  - LOAD: A, as address. STORE: A, as address.
  - MUL: low WIDTH bits of A·B.
  - NOP, jumps, CMP: result 0.
- reg_write_en = 1 for SUB, ADD, ADDI, SHLLI, SHRLI, LOAD, LOADI, MOV, MUL; 0 otherwise.
- Flags:
  - Arithmetic, shift and MUL set zf = (result==0) and clear gf and lf.
  - CMP sets zf = (A==B), lf = signed A<B, gf = signed A>B.
  - All other opcodes hold the flags.
  - Flags update on the accept edge (MUL: on its completion edge). The next accepted instruction therefore sees them.
- Branches:
  - JUMP: always taken, target = npc+B.
  - JUMPL/JUMPG/JUMPE/JUMPNE: taken when lf / gf / zf / !zf respectively, using the flag register at accept time. target = npc+1+sext(imm).
  - Not-taken branches and non-branches: branch_taken=0, target=0.
- MUL state machine:
  - IDLE → MUL on accept of opcode 16. Load the multiplicand and multiplier, clear the accumulator, counter=0, busy=1.
  - MUL: one shift-add per cycle. After WIDTH iterations, go to IDLE and load the output register with out_valid=1 and busy=0.
  - While busy, in_ready=0.
- Flush is synchronous:
  - Clears out_valid, branch_taken and reg_write_en.
  - Aborts MUL (returns to IDLE, busy=0).
  - Blocks accept that cycle.
  - Leaves the flags unchanged.
  - Flush overrides out_ready and in_valid.
- Reset: all outputs 0, FSM IDLE, flags 0. in_ready=1 in the first cycle after reset deasserts.

## Timing
- Single-cycle ops: accepted at edge N, out_valid=1 after edge N. Full throughput when out_ready=1.
- MUL: accepted at edge N, out_valid=1 after edge N+WIDTH.
- Stall: while out_valid && !out_ready, all outputs are held stable and in_ready=0.
- Output register updates on accept, or clears to out_valid=0 when consumed with no new accept.
- Simultaneous consume (out_ready) and accept: the output register is replaced by the new instruction with no bubble.
- Reset mid-MUL aborts the multiplication. Reset takes priority over flush.

## Test plan
- WIDTH=16. ADD A=0xFFFF, B=1 → result_out=0x0000, zf=1, reg_write_en=1, out_valid 1 cycle after accept.
- CMP A=0xFFFE (−2), B=3, then JUMPL npc=0x0010, imm=0x7E (−2) → lf=1, gf=0, zf=0; branch_taken=1, target=0x000F.
- MUL A=0x0123, B=0x0011 → busy for 16 cycles, in_ready=0 throughout; result_out=0x1353 exactly 16 cycles after the accept edge; zf=0.
- Back-pressure: stream ADDI ×3 with out_ready=0 after the first → first result is held stable and in_ready=0. Raising out_ready drains the results in order with no bubble.
- Flush during MUL (cycle 5) → busy=0 and out_valid=0 next cycle, flags unchanged; a following MOV B=0xBEEF gives result_out=0xBEEF.
- SHLLI A=0x0001, imm=16 → 0x0000, zf=1. Then NOP → flags held. Reset asserted → all outputs 0.
